// File: rtl/mem_port_arbiter_if.sv
// Requester/memory bundle for mem_port_arbiter: IF fetch port, MEM data port,
// single-port memory port, and the stall/busy status lines.
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ready;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          stall_if;
    logic          busy;

    // Arbiter side.
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_ready, d_rdata, d_ready,
        output mem_en, mem_we, mem_addr, mem_wdata, stall_if, busy
    );

    // Requester/memory side.
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_ready, d_rdata, d_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata, stall_if, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for a single-port unified memory with fixed wait states,
// data priority and a fetch starvation guard. ARB_PERF_EN adds perf counters.
module mem_port_arbiter #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned WAIT_CYC   = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                clrn,
    mem_port_arbiter_if.slave   bus
`ifdef ARB_PERF_EN
    ,
    output logic [31:0]         perf_if_wait,
    output logic [31:0]         perf_d_grant
`endif
);

    localparam int unsigned CW = 4;

    if (WAIT_CYC < 1 || WAIT_CYC > 15) begin : g_bad_wait
        $error("mem_port_arbiter: WAIT_CYC must be in 1..15");
    end
    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
        $error("mem_port_arbiter: STARVE_MAX must be in 1..15");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    state_e        state_q,     state_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic [CW-1:0] starve_q,    starve_d;
    logic          owner_q,     owner_d;      // 1 = data port owns the access
    logic          mem_en_q,    mem_en_d;
    logic          mem_we_q,    mem_we_d;
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] if_rdata_q,  if_rdata_d;
    logic [DW-1:0] d_rdata_q,   d_rdata_d;
    logic          if_ready_q,  if_ready_d;
    logic          d_ready_q,   d_ready_d;

    logic          grant_c;
    logic          data_grant_c;
    logic          stall_c;

    assign stall_c = bus.if_req & ~if_ready_q;

    // Next-state, arbitration and datapath capture.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        starve_d     = starve_q;
        owner_d      = owner_q;
        mem_en_d     = mem_en_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        if_ready_d   = 1'b0;
        d_ready_d    = 1'b0;
        grant_c      = 1'b0;
        data_grant_c = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.if_req | bus.d_req) begin
                    grant_c      = 1'b1;
                    // Data wins unless fetch has already waited STARVE_MAX grants.
                    data_grant_c = bus.d_req &
                                   ~(bus.if_req & (starve_q == CW'(STARVE_MAX)));
                    owner_d      = data_grant_c;
                    mem_en_d     = 1'b1;
                    mem_we_d     = data_grant_c & bus.d_we;
                    mem_addr_d   = data_grant_c ? bus.d_addr : bus.if_addr;
                    mem_wdata_d  = data_grant_c ? bus.d_wdata : '0;
                    cnt_d        = CW'(WAIT_CYC - 1);
                    state_d      = S_ACCESS;
                end

                if (!bus.if_req || !data_grant_c) begin
                    starve_d = '0;
                end else if (starve_q != CW'(STARVE_MAX)) begin
                    starve_d = starve_q + CW'(1);
                end
            end

            S_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    if (owner_q) begin
                        if (!mem_we_q) begin
                            d_rdata_d = bus.mem_rdata;
                        end
                        d_ready_d = 1'b1;
                    end else begin
                        if_rdata_d = bus.mem_rdata;
                        if_ready_d = 1'b1;
                    end
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    state_d  = S_RESP;
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            starve_q    <= '0;
            owner_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            owner_q     <= owner_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
        end
    end

    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.stall_if  = stall_c;
    assign bus.busy      = (state_q != S_IDLE);

`ifdef ARB_PERF_EN
    logic [31:0] perf_if_wait_q, perf_if_wait_d;
    logic [31:0] perf_d_grant_q, perf_d_grant_d;

    // Saturating event counters.
    always_comb begin
        perf_if_wait_d = perf_if_wait_q;
        perf_d_grant_d = perf_d_grant_q;
        if (stall_c && (perf_if_wait_q != 32'hFFFF_FFFF)) begin
            perf_if_wait_d = perf_if_wait_q + 32'd1;
        end
        if (grant_c && data_grant_c && (perf_d_grant_q != 32'hFFFF_FFFF)) begin
            perf_d_grant_d = perf_d_grant_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            perf_if_wait_q <= '0;
            perf_d_grant_q <= '0;
        end else begin
            perf_if_wait_q <= perf_if_wait_d;
            perf_d_grant_q <= perf_d_grant_d;
        end
    end

    assign perf_if_wait = perf_if_wait_q;
    assign perf_d_grant = perf_d_grant_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random
// traffic against a transaction/time-based reference model.
module tb_mem_port_arbiter;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int          W    = 2;
    localparam int          SMAX = 4;

    logic clk  = 1'b0;
    logic clrn = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

`ifdef ARB_PERF_EN
    logic [31:0] perf_if_wait;
    logic [31:0] perf_d_grant;
`endif

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .WAIT_CYC(W), .STARVE_MAX(SMAX)
    ) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
`ifdef ARB_PERF_EN
        ,
        .perf_if_wait (perf_if_wait),
        .perf_d_grant (perf_d_grant)
`endif
    );

    logic        use_fixed = 1'b0;
    logic [31:0] fixed_val = 32'h0;

    function automatic logic [31:0] mem_val(input logic [31:0] a, input logic uf,
                                            input logic [31:0] fv);
        return uf ? fv : ((a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F);
    endfunction

    // Memory model: data depends only on the presented address.
    assign bus.mem_rdata = bus.mem_en ? mem_val(bus.mem_addr, use_fixed, fixed_val) : '0;

    int          tests = 0;
    int          fails = 0;
    int          e = 0;
    int          g_edge = -1000;
    int          free_edge = 0;
    int          starve = 0;
    bit          g_data, g_we;
    logic [31:0] g_addr, g_wdata;
    logic [31:0] m_if_rdata = 32'h0;
    logic [31:0] m_d_rdata  = 32'h0;
    bit          last_if_rdy = 1'b0;
    bit          hold_req = 1'b0;
    longint      p_wait = 0;
    longint      p_dgr  = 0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock, predict the edge from the current inputs, check outputs.
    task automatic step();
        int ne;
        int d;
        bit pick_d, act, rdy, bsy;
        ne = e + 1;
        if (bus.if_req && !last_if_rdy) p_wait++;
        if (ne >= free_edge) begin
            if (bus.if_req || bus.d_req) begin
                pick_d    = bus.d_req && !(bus.if_req && starve == SMAX);
                g_data    = pick_d;
                g_edge    = ne;
                free_edge = ne + W + 2;
                if (pick_d) begin
                    g_we    = bus.d_we;
                    g_addr  = bus.d_addr;
                    g_wdata = bus.d_wdata;
                    starve  = bus.if_req ? ((starve < SMAX) ? starve + 1 : SMAX) : 0;
                    p_dgr++;
                end else begin
                    g_we    = 1'b0;
                    g_addr  = bus.if_addr;
                    g_wdata = 32'h0;
                    starve  = 0;
                end
            end else begin
                starve = 0;
            end
        end
        if (ne == g_edge + W) begin
            if (g_data) begin
                if (!g_we) m_d_rdata = mem_val(g_addr, use_fixed, fixed_val);
            end else begin
                m_if_rdata = mem_val(g_addr, use_fixed, fixed_val);
            end
        end

        @(posedge clk);
        #1;
        e   = ne;
        d   = e - g_edge;
        act = (d >= 0) && (d < W);
        rdy = (d == W);
        bsy = (d >= 0) && (d <= W);

        chk1("mem_en", bus.mem_en, act);
        chk1("mem_we", bus.mem_we, act && g_we);
        if (act) begin
            chk32("mem_addr", bus.mem_addr, g_addr);
            if (g_data) chk32("mem_wdata", bus.mem_wdata, g_wdata);
        end
        chk1("if_ready", bus.if_ready, rdy && !g_data);
        chk1("d_ready", bus.d_ready, rdy && g_data);
        chk32("if_rdata", bus.if_rdata, m_if_rdata);
        chk32("d_rdata", bus.d_rdata, m_d_rdata);
        chk1("busy", bus.busy, bsy);
        chk1("stall_if", bus.stall_if, bus.if_req && !(rdy && !g_data));
`ifdef ARB_PERF_EN
        chk32("perf_if_wait", perf_if_wait, 32'(p_wait));
        chk32("perf_d_grant", perf_d_grant, 32'(p_dgr));
`endif
        last_if_rdy = rdy && !g_data;

        if (bus.if_ready && !hold_req) bus.if_req = 1'b0;
        if (bus.d_ready  && !hold_req) bus.d_req  = 1'b0;
    endtask

    task automatic check_reset_zero(input string tag);
        chk1({tag, "_mem_en"}, bus.mem_en, 1'b0);
        chk1({tag, "_mem_we"}, bus.mem_we, 1'b0);
        chk32({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
        chk32({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
        chk1({tag, "_if_ready"}, bus.if_ready, 1'b0);
        chk1({tag, "_d_ready"}, bus.d_ready, 1'b0);
        chk32({tag, "_if_rdata"}, bus.if_rdata, 32'h0);
        chk32({tag, "_d_rdata"}, bus.d_rdata, 32'h0);
        chk1({tag, "_busy"}, bus.busy, 1'b0);
    endtask

    task automatic model_reset();
        g_edge      = -1000;
        free_edge   = 0;
        starve      = 0;
        m_if_rdata  = 32'h0;
        m_d_rdata   = 32'h0;
        last_if_rdy = 1'b0;
        p_wait      = 0;
        p_dgr       = 0;
    endtask

    byte   glog[$];
    string exp_pat;
    int    n_if, n_d;

    initial begin
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;

        // Power-on reset.
        repeat (2) @(posedge clk);
        #1;
        check_reset_zero("por");
        clrn = 1'b1;
        model_reset();

        // Single fetch with a known instruction word.
        use_fixed   = 1'b1;
        fixed_val   = 32'h8C01_0004;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0010;
        step();
        chk32("fetch_addr", bus.mem_addr, 32'h0000_0010);
        step();
        step();
        chk1("fetch_ready_c3", bus.if_ready, 1'b1);
        chk32("fetch_rdata_c3", bus.if_rdata, 32'h8C01_0004);
        step();
        chk1("fetch_busy_c4", bus.busy, 1'b0);
        chk1("fetch_ready_c4", bus.if_ready, 1'b0);
        use_fixed = 1'b0;
        step();

        // Store: memory sees the write, d_rdata stays at its reset value.
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h0000_0020;
        bus.d_wdata = 32'hDEAD_BEEF;
        step();
        chk1("store_we", bus.mem_we, 1'b1);
        chk32("store_addr", bus.mem_addr, 32'h0000_0020);
        chk32("store_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        step();
        step();
        chk1("store_ready", bus.d_ready, 1'b1);
        chk32("store_rdata_kept", bus.d_rdata, 32'h0);
        bus.d_we = 1'b0;
        repeat (2) step();

        // Both ports held continuously: starvation guard order.
        hold_req    = 1'b1;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_1000;
        bus.d_req   = 1'b1;
        bus.d_addr  = 32'h0000_2000;
        for (int i = 0; i < 60; i++) begin
            step();
            if (bus.d_ready)  glog.push_back(8'h44);
            if (bus.if_ready) glog.push_back(8'h46);
        end
        hold_req   = 1'b0;
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        exp_pat    = "DDDDFDDDDF";
        chk1("starve_grant_count", glog.size() >= 10, 1'b1);
        for (int i = 0; i < 10; i++) begin
            if (i < glog.size()) chk32("starve_order", 32'(glog[i]), 32'(exp_pat[i]));
        end
        repeat (6) step();

        // Fetch withdrawn during ACCESS, pending data granted next IDLE.
        n_if = 0;
        n_d  = 0;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0044;
        step();
        bus.if_req  = 1'b0;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h0000_0080;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.if_ready) n_if++;
            if (bus.d_ready)  n_d++;
        end
        chk32("withdraw_if_pulses", 32'(n_if), 32'd1);
        chk32("withdraw_d_pulses", 32'(n_d), 32'd1);
        chk32("withdraw_d_rdata", bus.d_rdata, mem_val(32'h0000_0080, 1'b0, 32'h0));

        // Reset in the middle of ACCESS.
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h0000_0100;
        step();
        #3;
        clrn = 1'b0;
        #1;
        check_reset_zero("midrst");
        bus.d_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clrn = 1'b1;
        model_reset();
        n_if = 0;
        n_d  = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.if_ready) n_if++;
            if (bus.d_ready)  n_d++;
        end
        chk32("midrst_no_ready", 32'(n_if + n_d), 32'd0);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0200;
        repeat (W + 1) step();
        chk1("midrst_new_ready", bus.if_ready, 1'b1);
        repeat (2) step();

        // Random traffic: scrambled inputs after grant and occasional withdrawal.
        for (int i = 0; i < 400; i++) begin
            step();
            if (g_edge == e) begin
                if (g_data) begin
                    bus.d_addr  = $urandom;
                    bus.d_wdata = $urandom;
                    bus.d_we    = 1'($urandom_range(0, 1));
                end else begin
                    bus.if_addr = $urandom;
                end
            end
            if ((e - g_edge) >= 0 && (e - g_edge) < W && $urandom_range(0, 7) == 0) begin
                if (g_data) bus.d_req = 1'b0;
                else        bus.if_req = 1'b0;
            end
            if (!bus.d_req && $urandom_range(0, 3) == 0) begin
                bus.d_req   = 1'b1;
                bus.d_we    = 1'($urandom_range(0, 1));
                bus.d_addr  = $urandom;
                bus.d_wdata = $urandom;
            end
            if (!bus.if_req && $urandom_range(0, 3) == 0) begin
                bus.if_req  = 1'b1;
                bus.if_addr = $urandom;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the 5-stage pipelined core.
- Sequences each access through a fixed number of memory wait states.
- Returns read data to the requester with a one-cycle ready pulse, and raises a fetch-stall for the hazard/stall logic.
- Data port has priority; a starvation guard bounds how long fetch can be blocked.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- WAIT_CYC, 2, memory access cycles per transfer; legal range 1..15.
- STARVE_MAX, 4, consecutive data grants allowed while a fetch waits before fetch is forced; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- clrn  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held high until if_ready.
- if_addr  in  AW  fetch address.
- if_rdata  out  DW  fetch read data; valid while if_ready=1.
- if_ready  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request; held high until d_ready.
- d_we  in  1  data write enable (1=store, 0=load).
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_rdata  out  DW  load data; valid while d_ready=1.
- d_ready  out  1  one-cycle completion pulse for data.
- mem_en  out  1  memory access active.
- mem_we  out  1  memory write strobe.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid in the last ACCESS cycle.
- stall_if  out  1  combinational: if_req & ~if_ready.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (clrn=0, asynchronous):
  - State goes to IDLE; counter, starve count and owner are cleared.
  - All registered outputs (if_rdata, d_rdata, if_ready, d_ready, mem_en, mem_we, mem_addr, mem_wdata) are 0.
  - Reset mid-access aborts the access; no ready pulse is issued afterwards.
- FSM states:
  - IDLE -> ACCESS when if_req|d_req. On that edge, latch owner, address, we and wdata into the mem_* registers, set mem_en=1, and load cnt=WAIT_CYC-1.
  - ACCESS: mem_* outputs are held constant. While cnt!=0, decrement cnt. When cnt==0, capture mem_rdata into the owner's rdata register, set the owner's ready=1, clear mem_en/mem_we, and go to RESP.
  - RESP: ready is high for exactly this cycle. Next state is IDLE; ready clears.
- Latency: request seen in IDLE at edge N gives the ready pulse in the cycle after edge N+WAIT_CYC, i.e. WAIT_CYC+1 cycles. Minimum spacing between grants is WAIT_CYC+2 cycles.
- Arbitration, evaluated only in IDLE:
  - d_req alone -> data. if_req alone -> fetch.
  - Both requesting -> data, unless starve==STARVE_MAX, in which case fetch.
- Starve counter:
  - Increments (saturating at STARVE_MAX) on each data grant while if_req=1.
  - Resets to 0 on any fetch grant, or when if_req=0 in IDLE.
- Writes:
  - mem_we=d_we for data grants; fetch grants always have mem_we=0.
  - d_rdata is not updated on stores; d_ready still pulses.
- Request withdrawal: if the owner drops its request during ACCESS, the access still completes and ready still pulses; the requester ignores it.
- Requester inputs are sampled only at the grant edge; changes during ACCESS have no effect.
- If the non-owner requests during ACCESS/RESP, it waits and is arbitrated in the next IDLE cycle.
- rdata registers hold their value between accesses.

Optional Feature:
- Macro: ARB_PERF_EN.
- When defined, add two outputs:
  - perf_if_wait (32 bits): increments every cycle stall_if=1.
  - perf_d_grant (32 bits): increments per data grant.
- Both counters saturate at 0xFFFFFFFF and reset to 0 on clrn.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then single fetch at 0x00000010 with mem_rdata=0x8C010004 and WAIT_CYC=2 -> mem_en high for 2 cycles, if_ready pulses exactly 1 cycle in cycle 3 with if_rdata=0x8C010004; busy=0 in cycle 4.
- Store d_addr=0x20, d_wdata=0xDEADBEEF -> mem_we=1, mem_addr=0x20, mem_wdata=0xDEADBEEF for 2 cycles; d_ready pulses; d_rdata unchanged.
- if_req and d_req both held high continuously with STARVE_MAX=4 -> grant order D,D,D,D,F,D,D,D,D,F…; stall_if high throughout except the fetch ready cycles.
- Fetch granted, then if_req dropped during ACCESS -> access completes, if_ready still pulses once; a pending d_req is granted in the following IDLE cycle.
- clrn asserted in the middle of ACCESS -> all outputs are 0 immediately; after release no ready pulse occurs; a new request completes normally in WAIT_CYC+1 cycles.
- With ARB_PERF_EN: 10 cycles of blocked fetch plus 3 data grants -> perf_if_wait=10, perf_d_grant=3.
